// File: rtl/sam_clk_pkg.sv
// Shared definitions for the SAMx4 CPU clock scheduler: phase encoding,
// SAM rate-select encodings and quarter-length helper.
package sam_clk_pkg;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

    localparam logic [1:0] RATE_SLOW = 2'b00;
    localparam logic [1:0] RATE_ADDR = 2'b01;
    localparam logic [1:0] RATE_FAST = 2'b10;

    localparam int DIV_SLOW_DEF  = 16;
    localparam int DIV_FAST_DEF  = 8;
    localparam int QLEN_SLOW_DEF = DIV_SLOW_DEF / 4;
    localparam int QLEN_FAST_DEF = DIV_FAST_DEF / 4;

    // One E period is four equal quarters.
    function automatic int qlen(input int div);
        return div / 4;
    endfunction

endpackage

// File: rtl/sam_cpu_clock_sched_if.sv
// CPU-side clock bus of the scheduler: rate/stall requests in, E/Q clocks and
// cycle status out.
interface sam_cpu_clock_sched_if;
    logic [1:0] rate_sel;
    logic       addr_fast;
    logic       stall;
    logic       e_clk;
    logic       q_clk;
    logic       cyc_start;
    logic       cyc_fast;
    logic       stall_to;

    modport slave (
        input  rate_sel, addr_fast, stall,
        output e_clk, q_clk, cyc_start, cyc_fast, stall_to
    );

    modport master (
        output rate_sel, addr_fast, stall,
        input  e_clk, q_clk, cyc_start, cyc_fast, stall_to
    );
endinterface

// File: rtl/sam_phase_timer.sv
// Loadable down-counter timing one E/Q quarter; tc_o flags the last clock of
// the quarter. It holds at zero until reloaded.
module sam_phase_timer #(
    parameter int             W       = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/sam_cpu_clock_sched.sv
// SAMx4 CPU E/Q quadrature clock scheduler: phase FSM, per-cycle rate latch
// and bounded PH1 stall stretching around a shared quarter timer.
module sam_cpu_clock_sched
    import sam_clk_pkg::*;
#(
    parameter int DIV_SLOW  = 16,
    parameter int DIV_FAST  = 8,
    parameter int STALL_MAX = 32
) (
    input  logic                 clk,
    input  logic                 rst,   // asynchronous, active-low
    sam_cpu_clock_sched_if.slave bus
);
    localparam int QLEN_SLOW = qlen(DIV_SLOW);
    localparam int QLEN_FAST = qlen(DIV_FAST);
    localparam int QW        = $clog2(QLEN_SLOW);
    localparam int SW        = $clog2(STALL_MAX + 1);

    localparam logic [QW-1:0] LOAD_SLOW = QW'(QLEN_SLOW - 1);
    localparam logic [QW-1:0] LOAD_FAST = QW'(QLEN_FAST - 1);
    localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);

    localparam logic [1:0] ST_PH0 = 2'(PH0);
    localparam logic [1:0] ST_PH1 = 2'(PH1);
    localparam logic [1:0] ST_PH2 = 2'(PH2);
    localparam logic [1:0] ST_PH3 = 2'(PH3);

    logic [1:0]    phase_q,     phase_d;
    logic          e_q,         e_d;
    logic          qc_q,        qc_d;
    logic          cyc_start_q, cyc_start_d;
    logic          cyc_fast_q,  cyc_fast_d;
    logic          stall_to_q,  stall_to_d;
    logic          stalling_q,  stalling_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    logic          tmr_load;
    logic [QW-1:0] tmr_val;
    logic          tmr_tc;
    logic          next_fast;

    // Reset acts as a slow PH0 entry, so the timer starts preloaded for a full quarter.
    sam_phase_timer #(
        .W       (QW),
        .RST_VAL (LOAD_SLOW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    assign next_fast = bus.rate_sel[1] | ((bus.rate_sel == RATE_ADDR) & bus.addr_fast);

    always_comb begin
        phase_d     = phase_q;
        e_d         = e_q;
        qc_d        = qc_q;
        cyc_start_d = 1'b0;
        cyc_fast_d  = cyc_fast_q;
        stall_to_d  = 1'b0;
        stalling_d  = stalling_q;
        stall_cnt_d = stall_cnt_q;
        tmr_load    = 1'b0;
        tmr_val     = cyc_fast_q ? LOAD_FAST : LOAD_SLOW;

        case (phase_q)
            ST_PH0: begin
                if (tmr_tc) begin
                    phase_d  = ST_PH1;
                    qc_d     = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            ST_PH1: begin
                if (stalling_q) begin
                    if (!bus.stall || (stall_cnt_q == STALL_LIM)) begin
                        phase_d     = ST_PH2;
                        e_d         = 1'b1;
                        tmr_load    = 1'b1;
                        stalling_d  = 1'b0;
                        stall_cnt_d = '0;
                        stall_to_d  = bus.stall;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end else if (tmr_tc) begin
                    if (bus.stall) begin
                        // The sampling clock is itself the first stretched clock.
                        stalling_d  = 1'b1;
                        stall_cnt_d = SW'(1);
                    end else begin
                        phase_d     = ST_PH2;
                        e_d         = 1'b1;
                        tmr_load    = 1'b1;
                        stall_cnt_d = '0;
                    end
                end
            end
            ST_PH2: begin
                if (tmr_tc) begin
                    phase_d  = ST_PH3;
                    qc_d     = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            default: begin
                if (tmr_tc) begin
                    phase_d     = ST_PH0;
                    e_d         = 1'b0;
                    cyc_start_d = 1'b1;
                    cyc_fast_d  = next_fast;
                    tmr_load    = 1'b1;
                    tmr_val     = next_fast ? LOAD_FAST : LOAD_SLOW;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q     <= ST_PH0;
            e_q         <= 1'b0;
            qc_q        <= 1'b0;
            cyc_start_q <= 1'b0;
            cyc_fast_q  <= 1'b0;
            stall_to_q  <= 1'b0;
            stalling_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            phase_q     <= phase_d;
            e_q         <= e_d;
            qc_q        <= qc_d;
            cyc_start_q <= cyc_start_d;
            cyc_fast_q  <= cyc_fast_d;
            stall_to_q  <= stall_to_d;
            stalling_q  <= stalling_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.e_clk     = e_q;
    assign bus.q_clk     = qc_q;
    assign bus.cyc_start = cyc_start_q;
    assign bus.cyc_fast  = cyc_fast_q;
    assign bus.stall_to  = stall_to_q;
endmodule

// File: tb/tb_sam_cpu_clock_sched.sv
// Directed bench for sam_cpu_clock_sched: edge-by-edge comparison of
// {e_clk,q_clk,cyc_start,cyc_fast,stall_to} against hand-derived cycle schedules.
module tb_sam_cpu_clock_sched;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    sam_cpu_clock_sched_if bus ();

    sam_cpu_clock_sched #(
        .DIV_SLOW  (16),
        .DIV_FAST  (8),
        .STALL_MAX (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [4:0] got_w;
    assign got_w = {bus.e_clk, bus.q_clk, bus.cyc_start, bus.cyc_fast, bus.stall_to};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs at edge k of an E cycle that began (entered PH0) at edge s,
    // with quarter length l, rate f, PH1 stretched by x clocks.
    function automatic logic [4:0] wave(input int k, input int s, input int l,
                                        input logic f, input int x,
                                        input logic pulse, input logic forced);
        logic e, q, cs, to;
        q  = (k >= s + l) && (k < s + 3 * l + x);
        e  = (k >= s + 2 * l + x);
        cs = pulse && (k == s);
        to = forced && (k == s + 2 * l + x);
        return {e, q, cs, f, to};
    endfunction

    task automatic release_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        bus.rate_sel  = 2'b00;
        bus.addr_fast = 1'b0;
        bus.stall     = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (got_w !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_state: got e,q,cs,fast,to=%b expected %b", got_w, 5'b00000);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k < 16) exp = wave(k, 0, 4, 1'b0, 0, 1'b0, 1'b0);
            else        exp = wave(k, 16, 4, 1'b0, 0, 1'b1, 1'b0);
            n_checks++;
            if (got_w !== exp) begin
                n_fail++;
                $display("FAIL reset_release k=%0d: got e,q,cs,fast,to=%b expected %b", k, got_w, exp);
            end
        end
    endtask

    task automatic test_rate_fast();
        logic [4:0] exp;
        bus.rate_sel  = 2'b00;
        bus.addr_fast = 1'b0;
        bus.stall     = 1'b0;
        release_reset();
        for (int k = 1; k <= 50; k++) begin
            if (k >= 6 && k < 20)       bus.rate_sel = 2'b10;
            else if (k >= 20 && k < 28) bus.rate_sel = 2'b11;
            else                        bus.rate_sel = 2'b00;
            @(posedge clk);
            #1;
            if (k < 16)      exp = wave(k, 0, 4, 1'b0, 0, 1'b0, 1'b0);
            else if (k < 24) exp = wave(k, 16, 2, 1'b1, 0, 1'b1, 1'b0);
            else if (k < 32) exp = wave(k, 24, 2, 1'b1, 0, 1'b1, 1'b0);
            else if (k < 48) exp = wave(k, 32, 4, 1'b0, 0, 1'b1, 1'b0);
            else             exp = wave(k, 48, 4, 1'b0, 0, 1'b1, 1'b0);
            n_checks++;
            if (got_w !== exp) begin
                n_fail++;
                $display("FAIL rate_fast k=%0d: got e,q,cs,fast,to=%b expected %b", k, got_w, exp);
            end
        end
        bus.rate_sel = 2'b00;
    endtask

    task automatic test_addr_mode();
        logic [4:0] exp;
        bus.rate_sel  = 2'b01;
        bus.addr_fast = 1'b0;
        bus.stall     = 1'b0;
        release_reset();
        for (int k = 1; k <= 47; k++) begin
            bus.addr_fast = ((k >= 12) && (k <= 17)) || ((k >= 20) && (k <= 22)) ||
                            ((k >= 28) && (k <= 35)) || (k >= 38);
            @(posedge clk);
            #1;
            if (k < 16)      exp = wave(k, 0, 4, 1'b0, 0, 1'b0, 1'b0);
            else if (k < 24) exp = wave(k, 16, 2, 1'b1, 0, 1'b1, 1'b0);
            else if (k < 40) exp = wave(k, 24, 4, 1'b0, 0, 1'b1, 1'b0);
            else             exp = wave(k, 40, 2, 1'b1, 0, 1'b1, 1'b0);
            n_checks++;
            if (got_w !== exp) begin
                n_fail++;
                $display("FAIL addr_mode k=%0d: got e,q,cs,fast,to=%b expected %b", k, got_w, exp);
            end
        end
        bus.rate_sel  = 2'b00;
        bus.addr_fast = 1'b0;
    endtask

    task automatic test_stall_short();
        logic [4:0] exp;
        bus.rate_sel  = 2'b00;
        bus.addr_fast = 1'b0;
        bus.stall     = 1'b0;
        release_reset();
        for (int k = 1; k <= 36; k++) begin
            bus.stall = ((k >= 2) && (k <= 3)) || ((k >= 8) && (k <= 12)) ||
                        (k == 15) || (k == 19);
            @(posedge clk);
            #1;
            if (k < 21) exp = wave(k, 0, 4, 1'b0, 5, 1'b0, 1'b0);
            else        exp = wave(k, 21, 4, 1'b0, 0, 1'b1, 1'b0);
            n_checks++;
            if (got_w !== exp) begin
                n_fail++;
                $display("FAIL stall_short k=%0d: got e,q,cs,fast,to=%b expected %b", k, got_w, exp);
            end
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_stall_hold();
        logic [4:0] exp;
        bus.rate_sel  = 2'b00;
        bus.addr_fast = 1'b0;
        bus.stall     = 1'b1;
        release_reset();
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (k < 48)      exp = wave(k, 0, 4, 1'b0, 32, 1'b0, 1'b1);
            else if (k < 96) exp = wave(k, 48, 4, 1'b0, 32, 1'b1, 1'b1);
            else             exp = wave(k, 96, 4, 1'b0, 32, 1'b1, 1'b1);
            n_checks++;
            if (got_w !== exp) begin
                n_fail++;
                $display("FAIL stall_hold k=%0d: got e,q,cs,fast,to=%b expected %b", k, got_w, exp);
            end
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        logic [4:0] exp;
        bus.rate_sel  = 2'b00;
        bus.addr_fast = 1'b0;
        bus.stall     = 1'b1;
        release_reset();
        repeat (20) @(posedge clk);
        #1;
        exp = wave(20, 0, 4, 1'b0, 32, 1'b0, 1'b1);
        n_checks++;
        if (got_w !== exp) begin
            n_fail++;
            $display("FAIL pre_reset_stall: got e,q,cs,fast,to=%b expected %b", got_w, exp);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (got_w !== 5'b00000) begin
            n_fail++;
            $display("FAIL async_reset: got e,q,cs,fast,to=%b expected %b", got_w, 5'b00000);
        end
        bus.stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k < 16) exp = wave(k, 0, 4, 1'b0, 0, 1'b0, 1'b0);
            else        exp = wave(k, 16, 4, 1'b0, 0, 1'b1, 1'b0);
            n_checks++;
            if (got_w !== exp) begin
                n_fail++;
                $display("FAIL after_reset k=%0d: got e,q,cs,fast,to=%b expected %b", k, got_w, exp);
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bus.rate_sel  = 2'b00;
        bus.addr_fast = 1'b0;
        bus.stall     = 1'b0;
        test_reset();
        test_rate_fast();
        test_addr_mode();
        test_stall_short();
        test_stall_hold();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
